// File: rtl/division100.sv
// division100: sequential divide-by-100 unit.
// Restoring shift-subtract divider that runs one iteration per clock for WIDTH
// iterations. It returns quotient and remainder, flags exact multiples of 100,
// and flags quotients too large to come from an 8-bit operand times 100.
module division100 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    output logic             busy,
    output logic             done,
    output logic [9:0]       quotient,
    output logic [6:0]       remainder,
    output logic             exact,
    output logic             ovf
);

    // Iteration counter runs WIDTH-1 down to 0.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Fixed divisor, held at trial-value width.
    localparam logic [7:0] DIVISOR = 8'd100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg;

    // Dividend shift register: its MSB feeds the partial remainder each
    // iteration.
    logic [WIDTH-1:0] dvd_reg;

    // The partial remainder is always below 100 between iterations, so
    // seven stored bits are enough.
    logic [6:0] rem_reg;

    // Quotient accumulator. The top bit of the full WIDTH-bit quotient only
    // exists on the final shift, so it is never stored.
    logic [WIDTH-2:0] qacc_reg;
    logic [CW-1:0]    cnt_reg;

    // Per-iteration datapath values.
    logic [7:0]       trial;
    logic             take;
    logic [7:0]       rem_next;
    logic [WIDTH-1:0] qacc_next;
    logic             ovf_next;

    // One restoring step: bring in the next dividend bit, then subtract the
    // divisor if it fits.
    always_comb begin
        trial     = {rem_reg, dvd_reg[WIDTH-1]};
        take      = (trial >= DIVISOR);
        rem_next  = take ? (trial - DIVISOR) : trial;
        qacc_next = {qacc_reg, take};
        ovf_next  = |qacc_next[WIDTH-1:8];
    end

    // Control FSM, iteration state and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            dvd_reg   <= '0;
            rem_reg   <= '0;
            qacc_reg  <= '0;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            exact     <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvd_reg   <= dividend;
                        rem_reg   <= '0;
                        qacc_reg  <= '0;
                        cnt_reg   <= CW'(WIDTH - 1);
                        busy      <= 1'b1;
                        state_reg <= DIV;
                    end
                end

                DIV: begin
                    dvd_reg  <= {dvd_reg[WIDTH-2:0], 1'b0};
                    rem_reg  <= rem_next[6:0];
                    qacc_reg <= qacc_next[WIDTH-2:0];
                    cnt_reg  <= cnt_reg - 1'b1;
                    if (cnt_reg == '0) begin
                        // Last iteration: publish the results together with
                        // the done pulse.
                        quotient  <= qacc_next[9:0];
                        remainder <= rem_next[6:0];
                        exact     <= (rem_next == 8'd0);
                        ovf       <= ovf_next;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end
                end

                DONE: begin
                    // start is deliberately ignored here; requests are not
                    // queued.
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_division100.sv
// Testbench for division100. Expected results come from plain integer
// division by 100 of each dividend.
module tb_division100;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic        busy;
    logic        done;
    logic [9:0]  quotient;
    logic [6:0]  remainder;
    logic        exact;
    logic        ovf;

    int checks;
    int failures;

    division100 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .exact     (exact),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Compare the result outputs against the arithmetic reference.
    task automatic check_result(input string tag, input int d);
        int q;
        int r;
        q = d / 100;
        r = d % 100;
        check({tag, ".quotient"}, 32'(quotient), 32'(q));
        check({tag, ".remainder"}, 32'(remainder), 32'(r));
        check({tag, ".exact"}, 32'(exact), 32'(r == 0));
        check({tag, ".ovf"}, 32'(ovf), 32'(q > 255));
    endtask

    // Run one division from IDLE. This checks latency, busy duration and
    // results, and that done drops after one cycle.
    task automatic run_op(input int d, input string tag);
        int lat;
        int bcnt;
        bit seen;
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'(d);
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        lat  = 0;
        bcnt = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1;
            lat++;
            if (done) seen = 1'b1;
        end
        check({tag, ".latency"}, 32'(lat), 32'd16);
        check({tag, ".busy_cycles"}, 32'(bcnt), 32'd16);
        check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        check_result(tag, d);
        $display("op %s dividend=%0d quotient=%0d remainder=%0d exact=%0d ovf=%0d latency=%0d",
                 tag, d, quotient, remainder, exact, ovf, lat);
        @(posedge clk);
        #1;
        check({tag, ".done_drop"}, 32'(done), 32'd0);
    endtask

    initial begin
        int extra_done;
        int extra_busy;
        int d;

        checks   = 0;
        failures = 0;
        start    = 1'b0;
        dividend = '0;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.quotient", 32'(quotient), 32'd0);
        check("reset.remainder", 32'(remainder), 32'd0);
        check("reset.exact", 32'(exact), 32'd0);
        check("reset.ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(0, "zero");

        // Every product of an 8-bit operand and 100.
        for (int i = 0; i <= 255; i++) begin
            run_op(i * 100, $sformatf("sweep%0d", i));
        end

        run_op(12345, "d12345");
        run_op(65535, "d65535");
        run_op(25600, "d25600");

        for (int i = 0; i < 60; i++) begin
            run_op(int'($urandom_range(0, 65535)), $sformatf("rand%0d", i));
        end

        // start pulses during DIV and during DONE must be dropped.
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'd12345;
        @(posedge clk);
        #1;
        extra_done = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            start    = (k == 5);
            dividend = (k >= 5) ? 16'd500 : 16'd12345;
            @(posedge clk);
            #1;
            if (k < 16 && done) extra_done++;
        end
        check("proto.done", 32'(done), 32'd1);
        check_result("proto", 12345);
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'd500;
        @(posedge clk);
        #1;
        check("proto.done_drop", 32'(done), 32'd0);
        @(negedge clk);
        start = 1'b0;
        extra_busy = 0;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk);
            #1;
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        check("proto.extra_done", 32'(extra_done), 32'd0);
        check("proto.extra_busy", 32'(extra_busy), 32'd0);
        check_result("proto.hold", 12345);
        $display("op proto dividend=12345 quotient=%0d remainder=%0d", quotient, remainder);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'd40000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("rst.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.quotient", 32'(quotient), 32'd0);
        check("rst.remainder", 32'(remainder), 32'd0);
        check("rst.exact", 32'(exact), 32'd0);
        check("rst.ovf", 32'(ovf), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        extra_done = 0;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) extra_done++;
        end
        check("rst.no_done", 32'(extra_done), 32'd0);
        $display("op reset_mid_div dividend=40000 quotient=%0d remainder=%0d", quotient, remainder);

        run_op(99, "after_rst99");

        d = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + d);
        $finish;
    end

endmodule
